// File: rtl/fact_mmio.sv
// Memory-mapped factorial engine: N (0..12) in, N! out; registers N/GO/STATUS/RESULT.
// Optional completion interrupt when FACT_IRQ_EN is defined.
module fact_mmio (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
`ifdef FACT_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy;

  assign busy = (state_q == LOAD) || (state_q == CALC);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    if (we && (a == 2'd0) && !busy) begin
      n_d = wd[3:0];
    end

    case (state_q)
      IDLE, DONE: begin
        if (we && (a == 2'd1) && wd[0]) begin
          state_d = LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        // 13! overflows 32 bits, so anything above 12 is rejected up front
        if (n_q > 4'd12) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = 32'd0;
        end else begin
          state_d  = CALC;
          result_d = 32'd1;
          cnt_d    = n_q;
        end
      end
      CALC: begin
        if (cnt_q > 4'd1) begin
          result_d = result_q * {28'd0, cnt_q};
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= 4'd0;
      cnt_q    <= 4'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef FACT_IRQ_EN
  logic irq_q;

  // Pulses on the first cycle spent in DONE; a reset abort never reaches DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state_q != DONE) && (state_d == DONE);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd = 32'd0;
    case (a)
      2'd0: rd = {28'd0, n_q};
      2'd1: rd = {31'd0, busy};
      2'd2: rd = {30'd0, err_q, done_q};
      2'd3: rd = result_q;
      default: rd = 32'd0;
    endcase
  end

endmodule
